// File: rtl/seven_segment_decoder.sv
`default_nettype none
// ============================================================================
// Module   : seven_segment_decoder
// Purpose  : Receive-side monitor for a multiplexed 8-digit seven-segment bus.
//            Samples anode/cathode lines, waits for each pattern to settle,
//            rebuilds the displayed digits, converts a complete numeric frame
//            back to binary and recognises the "OutOFrAn" banner.
// Ports    : clk          - system clock
//            rstn         - synchronous active-low reset
//            anode        - anode lines, active-low, bit0 = LED1 (rightmost)
//            select_seg   - cathode lines, active-low, {a,b,c,d,e,f,g,dp}
//            digits       - last complete frame, 4-bit code/digit, [31:28]=LED8
//            value        - binary value of last numeric frame
//            out_of_range - last frame was exactly the banner
//            frame_bad    - last frame held letters but was not the banner
//            frame_valid  - one-cycle pulse when digits/value/flags update
//            code_error   - one-cycle pulse: stable cathode not a known code
//            anode_error  - one-cycle pulse: stable anode with >1 bit low
// Revision : 1.0 - initial release
// ============================================================================
module seven_segment_decoder #(
    parameter int STABLE_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [7:0]  anode,
    input  logic [7:0]  select_seg,
    output logic [31:0] digits,
    output logic [26:0] value,
    output logic        out_of_range,
    output logic        frame_bad,
    output logic        frame_valid,
    output logic        code_error,
    output logic        anode_error
);

    localparam int                  c_CNT_W      = $clog2(STABLE_CYCLES + 1);
    localparam logic [c_CNT_W-1:0]  c_CNT_LAST   = c_CNT_W'(STABLE_CYCLES - 1);
    localparam logic [c_CNT_W-1:0]  c_CNT_MAX    = c_CNT_W'(STABLE_CYCLES);
    localparam logic [31:0]         c_BANNER     = 32'h0AB0CDEF;

    localparam logic [1:0]          c_ST_COLLECT = 2'd0;
    localparam logic [1:0]          c_ST_CONVERT = 2'd1;
    localparam logic [1:0]          c_ST_DONE    = 2'd2;

    // ------------------------------------------------------------------
    // Input stage and stability tracking
    // ------------------------------------------------------------------
    logic [7:0]         r_anode;
    logic [7:0]         r_seg;
    logic [7:0]         r_ref_anode;
    logic [7:0]         r_ref_seg;
    logic [c_CNT_W-1:0] r_cnt;

    logic               w_same;
    logic               w_accept;

    assign w_same   = (r_anode == r_ref_anode) && (r_seg == r_ref_seg);
    // The counter saturates at STABLE_CYCLES, so this fires once per run.
    assign w_accept = w_same && (r_cnt == c_CNT_LAST);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_anode     <= 8'hFF;
            r_seg       <= 8'hFF;
            r_ref_anode <= 8'hFF;
            r_ref_seg   <= 8'hFF;
            r_cnt       <= '0;
        end else begin
            r_anode <= anode;
            r_seg   <= select_seg;
            if (!w_same) begin
                r_ref_anode <= r_anode;
                r_ref_seg   <= r_seg;
                r_cnt       <= '0;
            end else if (r_cnt != c_CNT_MAX) begin
                r_cnt <= r_cnt + c_CNT_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Cathode pattern lookup; dp is part of the match so a lit dp misses.
    // Returns {hit, code}.
    // ------------------------------------------------------------------
    function automatic logic [4:0] decode_seg(input logic [7:0] seg);
        case (seg)
            8'b00000011: return {1'b1, 4'd0};
            8'b10011111: return {1'b1, 4'd1};
            8'b00100101: return {1'b1, 4'd2};
            8'b00001101: return {1'b1, 4'd3};
            8'b10011001: return {1'b1, 4'd4};
            8'b01001001: return {1'b1, 4'd5};
            8'b01000001: return {1'b1, 4'd6};
            8'b00011111: return {1'b1, 4'd7};
            8'b00000001: return {1'b1, 4'd8};
            8'b00001001: return {1'b1, 4'd9};
            8'b11000111: return {1'b1, 4'd10};
            8'b11100001: return {1'b1, 4'd11};
            8'b01110001: return {1'b1, 4'd12};
            8'b11110101: return {1'b1, 4'd13};
            8'b00010001: return {1'b1, 4'd14};
            8'b11010101: return {1'b1, 4'd15};
            default:     return 5'd0;
        endcase
    endfunction

    // ------------------------------------------------------------------
    // Accept-event classification and slot write
    // ------------------------------------------------------------------
    logic [7:0]  w_low;
    logic        w_one_low;
    logic        w_multi_low;
    logic [2:0]  w_slot_idx;
    logic [4:0]  w_dec;
    logic        w_write;
    logic        w_code_err;
    logic        w_anode_err;
    logic [7:0]  w_mask_next;
    logic [31:0] w_slots_next;

    logic [7:0]  r_mask;
    logic [31:0] r_slots;

    always_comb begin
        w_low       = ~r_anode;
        // Clearing the lowest set bit leaves zero only for a single low line.
        w_one_low   = (w_low != 8'd0) && ((w_low & (w_low - 8'd1)) == 8'd0);
        w_multi_low = (w_low != 8'd0) && !w_one_low;
        w_slot_idx  = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (w_low[i]) begin
                w_slot_idx = 3'(i);
            end
        end
    end

    assign w_dec       = decode_seg(r_seg);
    assign w_write     = w_accept && w_one_low && w_dec[4];
    assign w_code_err  = w_accept && w_one_low && !w_dec[4];
    assign w_anode_err = w_accept && w_multi_low;

    // Next-state view of slots/mask so a write on the completing edge is
    // included in the snapshot.
    always_comb begin
        w_slots_next = r_slots;
        w_mask_next  = r_mask;
        if (w_write) begin
            w_slots_next[{w_slot_idx, 2'b00} +: 4] = w_dec[3:0];
            w_mask_next[w_slot_idx]                = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Frame FSM: collect -> convert (8 digits, LED8 first) -> done
    // ------------------------------------------------------------------
    logic [1:0]  r_state;
    logic [31:0] r_snap;
    logic [31:0] r_work;
    logic [26:0] r_acc;
    logic        r_letter;
    logic [2:0]  r_step;

    logic [31:0] r_digits;
    logic [26:0] r_value;
    logic        r_out_of_range;
    logic        r_frame_bad;
    logic        r_frame_valid;
    logic        r_code_error;
    logic        r_anode_error;

    logic [26:0] w_acc_next;

    // acc*10 as two shifts; the largest frame value fits in 27 bits.
    assign w_acc_next = (r_acc << 3) + (r_acc << 1) + 27'(r_work[31:28]);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state        <= c_ST_COLLECT;
            r_mask         <= 8'd0;
            r_slots        <= 32'd0;
            r_snap         <= 32'd0;
            r_work         <= 32'd0;
            r_acc          <= 27'd0;
            r_letter       <= 1'b0;
            r_step         <= 3'd0;
            r_digits       <= 32'd0;
            r_value        <= 27'd0;
            r_out_of_range <= 1'b0;
            r_frame_bad    <= 1'b0;
            r_frame_valid  <= 1'b0;
            r_code_error   <= 1'b0;
            r_anode_error  <= 1'b0;
        end else begin
            r_frame_valid <= 1'b0;
            r_code_error  <= w_code_err;
            r_anode_error <= w_anode_err;
            // Live slots keep updating in every state; the snapshot isolates
            // the frame under conversion.
            r_slots       <= w_slots_next;
            r_mask        <= w_mask_next;

            case (r_state)
                c_ST_COLLECT: begin
                    if (w_mask_next == 8'hFF) begin
                        r_snap   <= w_slots_next;
                        r_work   <= w_slots_next;
                        r_mask   <= 8'd0;
                        r_acc    <= 27'd0;
                        r_letter <= 1'b0;
                        r_step   <= 3'd0;
                        r_state  <= c_ST_CONVERT;
                    end
                end

                c_ST_CONVERT: begin
                    r_acc    <= w_acc_next;
                    r_letter <= r_letter | (r_work[31:28] > 4'd9);
                    r_work   <= {r_work[27:0], 4'h0};
                    r_step   <= r_step + 3'd1;
                    if (r_step == 3'd7) begin
                        r_state <= c_ST_DONE;
                    end
                end

                c_ST_DONE: begin
                    r_digits      <= r_snap;
                    r_frame_valid <= 1'b1;
                    if (r_snap == c_BANNER) begin
                        r_out_of_range <= 1'b1;
                        r_frame_bad    <= 1'b0;
                        r_value        <= 27'd0;
                    end else if (r_letter) begin
                        r_out_of_range <= 1'b0;
                        r_frame_bad    <= 1'b1;
                        r_value        <= 27'd0;
                    end else begin
                        r_out_of_range <= 1'b0;
                        r_frame_bad    <= 1'b0;
                        r_value        <= r_acc;
                    end
                    r_state <= c_ST_COLLECT;
                end

                default: begin
                    r_state <= c_ST_COLLECT;
                end
            endcase
        end
    end

    assign digits       = r_digits;
    assign value        = r_value;
    assign out_of_range = r_out_of_range;
    assign frame_bad    = r_frame_bad;
    assign frame_valid  = r_frame_valid;
    assign code_error   = r_code_error;
    assign anode_error  = r_anode_error;

endmodule
`default_nettype wire

// File: doc/seven_segment_decoder.md
# seven_segment_decoder

Receive-side monitor for the multiplexed 8-digit seven-segment bus. It samples the anode and cathode lines driven by the display controller and reconstructs the displayed digits. It then converts a complete numeric frame back to a 27-bit binary value and flags the "OutOFrAn" out-of-range banner. It sits on the board-level self-check path and in benches as the scoreboard-side decoder of the display interface.

## Interface
- STABLE_CYCLES, 1024: consecutive identical samples required before a digit is accepted (>=2).
- clk  in  1  system clock
- rstn  in  1  reset; one clock, synchronous, active-low
- anode  in  8  anode lines, active-low; bit0 = LED1 (rightmost), bit7 = LED8
- select_seg  in  8  cathode lines, active-low, bit order {a,b,c,d,e,f,g,dp}
- digits  out  32  last complete frame, 4-bit code per digit, [31:28] = LED8
- value  out  27  binary value of last numeric frame
- out_of_range  out  1  last frame was exactly the banner
- frame_bad  out  1  last frame contained letters but was not the banner
- frame_valid  out  1  one-cycle pulse when digits/value/flags update
- code_error  out  1  one-cycle pulse: stable pattern not in code table
- anode_error  out  1  one-cycle pulse: stable anode with more than one bit low

## Operation
- Input stage: anode/select_seg are registered once (reset value 8'hFF each). Stability counter runs on registered values. Any change resets the run. The counter saturates, so each run fires at most one accept event.
- Accept event, when the run reaches STABLE_CYCLES samples:
  - anode == 8'hFF (blank): ignored.
  - Exactly one bit low: that is the slot index.
  - More than one bit low: anode_error pulse, no write.
  - The cathode is decoded per the table below. If it matches a code, the slot register is written and its mask bit is set. If it does not match, code_error pulses and nothing is written.
- Code table (code: pattern):
  - 0 ("0"/"O"): 00000011
  - 1: 10011111
  - 2: 00100101
  - 3: 00001101
  - 4: 10011001
  - 5: 01001001
  - 6: 01000001
  - 7: 00011111
  - 8: 00000001
  - 9: 00001001
  - 10 "u": 11000111
  - 11 "t": 11100001
  - 12 "F": 01110001
  - 13 "r": 11110101
  - 14 "A": 00010001
  - 15 "n": 11010101
  - dp is part of the match; dp lit means no match.
- A rewritten slot overwrites its old value. The mask bit stays set.
- FSM states:
  - COLLECT: when mask becomes 8'hFF (counting the write on this edge), snapshot all slots, clear mask, go to CONVERT.
  - CONVERT: 8 cycles, LED8 first. acc <= acc*10 + code, 27-bit, accumulator starts at 0. Any code >9 sets an internal letter flag.
  - DONE: 1 cycle. digits <= snapshot; frame_valid = 1. Flags and value update as follows:
    - Snapshot == {0,10,11,0,12,13,14,15} (LED8..LED1): out_of_range = 1, frame_bad = 0, value = 0.
    - Letter flag set otherwise: frame_bad = 1, out_of_range = 0, value = 0.
    - Else: value = acc, both flags 0. Return to COLLECT.
- Slot writes continue during CONVERT/DONE into the live slot registers and mask. They do not affect the snapshot in flight. A mask that fills during CONVERT/DONE is taken on the first COLLECT cycle.
- Max numeric value 99,999,999 fits in 27 bits, so there is no overflow.

## Timing
- Reset (rstn low at an edge): all outputs 0, mask 0, counter 0, FSM COLLECT, input regs 8'hFF. Reset mid-CONVERT discards the frame, and no frame_valid is produced.
- A pattern presented on edges N..N+STABLE_CYCLES is written (or an error pulses) at edge N+STABLE_CYCLES+1. This is one cycle of input register plus STABLE_CYCLES samples.
- Mask completes at edge F → frame_valid high for the cycle after edge F+9. digits/value/flags are valid from that same edge and held until the next DONE.
- Error pulses last exactly one cycle. They are independent of the FSM and may coincide with frame_valid.
- A pattern held shorter than STABLE_CYCLES (ghosting during digit switch) is never written.

## Test plan
- Bench uses STABLE_CYCLES=4, 16 cycles per digit, scan LED1..LED8.
- Numeric frame, digits 1,2,3,4,5,6,7,8 (LED8..LED1) → one frame_valid, value = 12345678, digits = 32'h12345678, flags 0. Repeat with 99999999 → value = 27'd99999999.
- Banner patterns "OutOFrAn" → out_of_range = 1, value = 0, digits = 32'h0AB0CDEF, frame_bad = 0.
- Frame with LED3 = "A", others numeric → frame_bad = 1, out_of_range = 0, value = 0.
- Cathode 8'hFE (dp lit) stable on LED2 → one code_error pulse, and no frame_valid until LED2 is rescanned with a valid code. Anode 8'hFC stable → one anode_error pulse.
- 3-cycle glitch pattern between digits → no write and no error. Then assert rstn low during CONVERT → all outputs 0, no frame_valid. The next full scan decodes normally.
